// File: rtl/decode_instr_encoder_pkg.sv
// Shared decode/encode types.
// Purpose : opcode / funct3 / immediate-format types used by the decoder
//           and by the instruction encoder, plus the encoder error code.
// Contents: opcode_t, funct3_t, OPCODE_* constants, imm_type_t, enc_err_t,
//           upper_uniform() helper for sign-extension range checks.
package decode_instr_encoder_pkg;

  typedef logic [6:0] opcode_t;
  typedef logic [2:0] funct3_t;

  localparam opcode_t OPCODE_LOAD   = 7'h03;
  localparam opcode_t OPCODE_OP_IMM = 7'h13;
  localparam opcode_t OPCODE_AUIPC  = 7'h17;
  localparam opcode_t OPCODE_STORE  = 7'h23;
  localparam opcode_t OPCODE_OP     = 7'h33;
  localparam opcode_t OPCODE_LUI    = 7'h37;
  localparam opcode_t OPCODE_BRANCH = 7'h63;
  localparam opcode_t OPCODE_JALR   = 7'h67;
  localparam opcode_t OPCODE_JAL    = 7'h6F;
  localparam opcode_t OPCODE_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_C    = 3'd6
  } imm_type_t;

  typedef enum logic [1:0] {
    ENC_OK    = 2'd0,
    ENC_ALIGN = 2'd1,
    ENC_RANGE = 2'd2
  } enc_err_t;

  // True when v[31:lsb] is all zeros or all ones, i.e. v is representable
  // as a sign-extended (lsb+1)-bit value.
  function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << lsb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction

endpackage

// File: rtl/decode_instr_encoder_imm_scatter.sv
// encode_imm_scatter: purely combinational immediate scatter.
// Ports:
//   imm      in  32  immediate (byte offset / full value)
//   imm_type in      packing format
//   imm_bits out 32  immediate contribution in instruction-word positions
//   imm_mask out 32  1 where the instruction word bit comes from imm_bits
module encode_imm_scatter
  import decode_instr_encoder_pkg::*;
(
  input  logic [31:0] imm,
  input  imm_type_t   imm_type,
  output logic [31:0] imm_bits,
  output logic [31:0] imm_mask
);

  always_comb begin
    imm_bits = '0;
    imm_mask = '0;
    case (imm_type)
      IMM_I: begin
        imm_bits[31:20] = imm[11:0];
        imm_mask[31:20] = '1;
      end
      IMM_S: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        imm_mask[31:25] = '1;
        imm_mask[11:7]  = '1;
      end
      IMM_B: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        imm_mask[31:25] = '1;
        imm_mask[11:7]  = '1;
      end
      IMM_U: begin
        imm_bits[31:12] = imm[31:12];
        imm_mask[31:12] = '1;
      end
      IMM_J: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        imm_mask[31:12] = '1;
      end
      IMM_C: begin
        // zimm occupies the rs1 slot; the CSR address is placed by the top.
        imm_bits[19:15] = imm[4:0];
        imm_mask[19:15] = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_instr_encoder.sv
// decode_instr_encoder: packs discrete instruction fields into an RV32 word
// and queues it in a small output FIFO.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid / in_ready field bundle handshake (in_ready = FIFO not full)
//   opcode_i .. imm_i   instruction fields, imm_type_i selects the format
//   out_valid/out_ready FIFO head handshake
//   instr_o, err_o      encoded word and error code at the FIFO head
// Parameter DEPTH: FIFO entries, power of two, >= 2.
// Build option: define ENC_RANGE_CHECK_EN to enable immediate alignment /
// range checking on err_o; otherwise err_o is constantly ENC_OK.
//
// Handshake: a transfer happens on any rising clk edge where valid && ready
// are both high. in_ready depends only on FIFO fullness (never on
// out_ready), so a pop in the same cycle as a full FIFO does not admit a
// push. A pushed bundle is visible at the head one cycle after its edge.
// While out_valid && !out_ready the head outputs do not change.
module decode_instr_encoder
  import decode_instr_encoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  opcode_t     opcode_i,
  input  logic [4:0]  rd_i,
  input  funct3_t     funct3_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [6:0]  funct7_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] imm_i,
  input  imm_type_t   imm_type_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_o,
  output enc_err_t    err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0] imm_bits;
  logic [31:0] imm_mask;
  logic [31:0] fixed_word;
  logic [31:0] enc_word;
  enc_err_t    enc_err;

  encode_imm_scatter u_scatter (
    .imm      (imm_i),
    .imm_type (imm_type_i),
    .imm_bits (imm_bits),
    .imm_mask (imm_mask)
  );

  // R-type layout as the base; the immediate mask then overwrites whichever
  // register/funct fields the selected format does not use.
  always_comb begin
    fixed_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
    if (imm_type_i == IMM_C) fixed_word[31:20] = csr_addr_i;
  end

  assign enc_word = (fixed_word & ~imm_mask) | (imm_bits & imm_mask);

`ifdef ENC_RANGE_CHECK_EN
  // Alignment is reported in preference to range.
  always_comb begin
    enc_err = ENC_OK;
    case (imm_type_i)
      IMM_I, IMM_S: if (!upper_uniform(imm_i, 11)) enc_err = ENC_RANGE;
      IMM_B: begin
        if (imm_i[0])                         enc_err = ENC_ALIGN;
        else if (!upper_uniform(imm_i, 12))   enc_err = ENC_RANGE;
      end
      IMM_J: begin
        if (imm_i[0])                         enc_err = ENC_ALIGN;
        else if (!upper_uniform(imm_i, 20))   enc_err = ENC_RANGE;
      end
      IMM_U: if (imm_i[11:0] != 12'h0)        enc_err = ENC_ALIGN;
      IMM_C: if (imm_i[31:5] != 27'h0)        enc_err = ENC_RANGE;
      default: ;
    endcase
  end
`else
  assign enc_err = ENC_OK;
`endif

  // Output FIFO
  logic [31:0]   mem_instr [DEPTH];
  enc_err_t      mem_err   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   last_instr;
  enc_err_t      last_err;
  logic          full, empty, push, pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_instr <= '0;
      last_err   <= ENC_OK;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_err[i]   <= ENC_OK;
      end
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= enc_word;
        mem_err[wr_ptr]   <= enc_err;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        // Remember the departing head so the outputs hold it once empty.
        last_instr <= mem_instr[rd_ptr];
        last_err   <= mem_err[rd_ptr];
        rd_ptr     <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign instr_o = empty ? last_instr : mem_instr[rd_ptr];
  assign err_o   = empty ? last_err   : mem_err[rd_ptr];

endmodule

// File: tb/tb_decode_instr_encoder.sv
// Directed bench for decode_instr_encoder with a head-of-FIFO scoreboard.
module tb_decode_instr_encoder;
  import decode_instr_encoder_pkg::*;

  localparam int DEPTH = 2;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  opcode_t     opcode_i;
  logic [4:0]  rd_i;
  funct3_t     funct3_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [6:0]  funct7_i;
  logic [11:0] csr_addr_i;
  logic [31:0] imm_i;
  imm_type_t   imm_type_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_o;
  enc_err_t    err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [33:0] exp_q[$];
  logic [33:0] cur_exp;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  decode_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode_i   (opcode_i),
    .rd_i       (rd_i),
    .funct3_i   (funct3_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .funct7_i   (funct7_i),
    .csr_addr_i (csr_addr_i),
    .imm_i      (imm_i),
    .imm_type_i (imm_type_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_o    (instr_o),
    .err_o      (err_o)
  );

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sampling point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver
  task automatic drive(input opcode_t op, input logic [4:0] rd, input funct3_t f3,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                       input logic [11:0] csr, input logic [31:0] imm, input imm_type_t t,
                       input logic [31:0] e_instr, input enc_err_t e_err);
    opcode_i   = op;
    rd_i       = rd;
    funct3_i   = f3;
    rs1_i      = rs1;
    rs2_i      = rs2;
    funct7_i   = f7;
    csr_addr_i = csr;
    imm_i      = imm;
    imm_type_i = t;
    cur_exp    = {e_err, e_instr};
    in_valid   = 1'b1;
  endtask

  // Single bundle into an empty FIFO: accept, check head one cycle later, drain.
  task automatic enc_vec(input string tag, input opcode_t op, input logic [4:0] rd,
                         input funct3_t f3, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [6:0] f7, input logic [11:0] csr, input logic [31:0] imm,
                         input imm_type_t t, input logic [31:0] e_instr, input enc_err_t e_err);
    out_ready = 1'b0;
    drive(op, rd, f3, rs1, rs2, f7, csr, imm, t, e_instr, e_err);
    check({tag, "_in_ready"}, 34'(in_ready), 34'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_valid"}, 34'(out_valid), 34'd1);
    check({tag, "_instr"}, 34'(instr_o), 34'(e_instr));
    check({tag, "_err"}, 34'(err_o), 34'(e_err));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drained"}, 34'(out_valid), 34'd0);
  endtask

  // scoreboard: handshakes decided at the next rising edge, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_pop_without_expect", 34'(exp_q.size()), 34'd1);
        else                   check("sb_head", {err_o, instr_o}, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    opcode_i   = '0;
    rd_i       = '0;
    funct3_i   = '0;
    rs1_i      = '0;
    rs2_i      = '0;
    funct7_i   = '0;
    csr_addr_i = '0;
    imm_i      = '0;
    imm_type_i = IMM_NONE;
    cur_exp    = '0;

    #2;
    check("reset_out_valid", 34'(out_valid), 34'd0);
    check("reset_in_ready", 34'(in_ready), 34'd1);
    check("reset_instr", 34'(instr_o), 34'd0);
    check("reset_err", 34'(err_o), 34'(ENC_OK));
    tick();
    tick();
    rst = 1'b0;

    // directed vectors
    enc_vec("addi", OPCODE_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0,
            32'd5, IMM_I, 32'h0050_0093, ENC_OK);
    enc_vec("beq", OPCODE_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0,
            32'hFFFF_FFFC, IMM_B, 32'hFE00_0EE3, ENC_OK);
    enc_vec("lui", OPCODE_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0,
            32'h1234_5000, IMM_U, 32'h1234_52B7, ENC_OK);
    enc_vec("sw", OPCODE_STORE, 5'd31, 3'd2, 5'd1, 5'd2, 7'h7F, 12'hABC,
            32'd8, IMM_S, 32'h0020_A423, ENC_OK);
    enc_vec("sw_neg", OPCODE_STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 12'd0,
            32'hFFFF_FFF8, IMM_S, 32'hFE20_AC23, ENC_OK);
    enc_vec("jal", OPCODE_JAL, 5'd1, 3'd3, 5'd5, 5'd7, 7'd0, 12'd0,
            32'h0000_0800, IMM_J, 32'h0010_00EF, ENC_OK);
    enc_vec("csrrwi", OPCODE_SYSTEM, 5'd3, 3'd5, 5'd31, 5'd31, 7'h7F, 12'h300,
            32'd5, IMM_C, 32'h3002_D1F3, ENC_OK);
    enc_vec("sub", OPCODE_OP, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 12'hFFF,
            32'hFFFF_FFFF, IMM_NONE, 32'h4020_81B3, ENC_OK);

    // error cases: word is still packed by truncation
    enc_vec("b_misalign", OPCODE_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0,
            32'd3, IMM_B, 32'h0000_0163, CHK_EN ? ENC_ALIGN : ENC_OK);
    enc_vec("j_range", OPCODE_JAL, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0,
            32'h0010_0000, IMM_J, 32'h8000_006F, CHK_EN ? ENC_RANGE : ENC_OK);
    enc_vec("u_align", OPCODE_LUI, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0,
            32'd1, IMM_U, 32'h0000_0037, CHK_EN ? ENC_ALIGN : ENC_OK);
    enc_vec("i_range", OPCODE_OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0,
            32'h0000_0800, IMM_I, 32'h8000_0013, CHK_EN ? ENC_RANGE : ENC_OK);
    enc_vec("c_range", OPCODE_SYSTEM, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0,
            32'h0000_0020, IMM_C, 32'h0000_0073, CHK_EN ? ENC_RANGE : ENC_OK);

    // backpressure: three bundles, consumer stalled
    out_ready = 1'b0;
    drive(OPCODE_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0, 32'd1, IMM_I, 32'h0010_0093, ENC_OK);
    tick();
    check("bp_ready_after_1", 34'(in_ready), 34'd1);
    drive(OPCODE_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0, 32'd2, IMM_I, 32'h0020_0093, ENC_OK);
    tick();
    check("bp_ready_after_2", 34'(in_ready), 34'd0);
    check("bp_head_a", 34'(instr_o), 34'h0010_0093);
    drive(OPCODE_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0, 32'd3, IMM_I, 32'h0030_0093, ENC_OK);
    tick();
    check("bp_still_full", 34'(in_ready), 34'd0);
    check("bp_head_stable", 34'(instr_o), 34'h0010_0093);
    out_ready = 1'b1;
    tick();
    check("bp_head_b", 34'(instr_o), 34'h0020_0093);
    check("bp_ready_after_pop", 34'(in_ready), 34'd1);
    tick();
    in_valid = 1'b0;
    check("bp_head_c", 34'(instr_o), 34'h0030_0093);
    tick();
    out_ready = 1'b0;
    check("bp_drained", 34'(out_valid), 34'd0);

    // asynchronous reset with two entries queued
    drive(OPCODE_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0, 32'd7, IMM_I, 32'h0070_0093, ENC_OK);
    tick();
    drive(OPCODE_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0, 32'd8, IMM_I, 32'h0080_0093, ENC_OK);
    tick();
    in_valid = 1'b0;
    check("pre_rst_full", 34'(in_ready), 34'd0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_in_ready", 34'(in_ready), 34'd1);
    check("rst_instr", 34'(instr_o), 34'd0);
    tick();
    rst = 1'b0;
    check("post_rst_empty", 34'(out_valid), 34'd0);
    enc_vec("post_rst_lui", OPCODE_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 12'd0,
            32'h1234_5000, IMM_U, 32'h1234_52B7, ENC_OK);

    tick();
    check("sb_queue_empty", 34'(exp_q.size()), 34'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
